// File: rtl/k12a_spi_slave_if.sv
// Bus-side signals of k12a_spi_slave: CPU I/O strobes, status flags and the SPI master inputs.
// The tristate data_bus and spi_miso stay as plain ports of the block.
interface k12a_spi_slave_if;
    logic spi_slave_data_io_load;
    logic spi_slave_data_io_store;
    logic spi_slave_status_io_load;
    logic spi_slave_rx_ready;
    logic spi_slave_selected;
    logic spi_sck;
    logic spi_mosi;
    logic spi_ss_n;

    modport slave (
        input  spi_slave_data_io_load,
        input  spi_slave_data_io_store,
        input  spi_slave_status_io_load,
        input  spi_sck,
        input  spi_mosi,
        input  spi_ss_n,
        output spi_slave_rx_ready,
        output spi_slave_selected
    );

    modport master (
        output spi_slave_data_io_load,
        output spi_slave_data_io_store,
        output spi_slave_status_io_load,
        output spi_sck,
        output spi_mosi,
        output spi_ss_n,
        input  spi_slave_rx_ready,
        input  spi_slave_selected
    );
endinterface

// File: rtl/k12a_spi_slave.sv
// SPI mode-0 slave (MSB first, 8-bit frames) with a CPU-side receive/transmit/status register set.
// Define K12A_SPI_SLAVE_OVERRUN_EN to add the overrun flag (status bit 1).
module k12a_spi_slave (
    input  logic                   cpu_clock,
    input  logic                   reset_n,
    k12a_spi_slave_if.slave        bus,
    inout  wire  [7:0]             data_bus,
    output wire                    spi_miso
);
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_sck_s;
    logic [2:0]  r_mosi_s;
    logic [2:0]  r_ss_s;
    logic [7:0]  r_shift;
    logic [2:0]  r_cnt;
    logic [7:0]  r_rx_data;
    logic [7:0]  r_tx_data;
    logic        r_rx_ready;
    logic        r_miso;

    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_mosi_sync;
    logic        w_ss_fall;
    logic        w_ss_high;
    logic        w_enter;
    logic        w_active;
    logic        w_complete;
    logic        w_overrun;
    logic        w_selected;
    logic        w_bus_en;
    logic [7:0]  w_bus_val;

    // ss_n synchroniser resets low so that a select held through reset is not seen as a fresh edge
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_s  <= 3'b000;
            r_mosi_s <= 3'b000;
            r_ss_s   <= 3'b000;
        end else begin
            r_sck_s  <= {r_sck_s[1:0],  bus.spi_sck};
            r_mosi_s <= {r_mosi_s[1:0], bus.spi_mosi};
            r_ss_s   <= {r_ss_s[1:0],   bus.spi_ss_n};
        end
    end

    assign w_sck_rise  = r_sck_s[1] & ~r_sck_s[2];
    assign w_sck_fall  = ~r_sck_s[1] & r_sck_s[2];
    assign w_ss_fall   = ~r_ss_s[1] & r_ss_s[2];
    assign w_ss_high   = r_ss_s[1];
    // MOSI settles at least three cycles before SCK rises, so the third flop is still current
    assign w_mosi_sync = r_mosi_s[2];

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall) w_state_next = SHIFT;
            SHIFT:   if (w_ss_high) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_selected = (r_state == SHIFT);
    end

    assign w_enter    = (r_state == IDLE) && w_ss_fall;
    assign w_active   = (r_state == SHIFT) && !w_ss_high;
    assign w_complete = w_active && w_sck_rise && (r_cnt == 3'd7);

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= 8'h00;
            r_cnt      <= 3'd0;
            r_rx_data  <= 8'h00;
            r_tx_data  <= 8'h00;
            r_rx_ready <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            if (bus.spi_slave_data_io_store) r_tx_data <= data_bus;
            if (w_complete) r_rx_data <= {r_shift[6:0], w_mosi_sync};
            r_rx_ready <= w_complete | (r_rx_ready & ~bus.spi_slave_data_io_load);

            if (w_enter) begin
                r_shift <= r_tx_data;
                r_cnt   <= 3'd0;
                r_miso  <= r_tx_data[7];
            end else if (w_active) begin
                if (w_sck_rise) begin
                    r_cnt   <= r_cnt + 3'd1;
                    // reload at the byte boundary so the next frame follows without a gap
                    r_shift <= (r_cnt == 3'd7) ? r_tx_data : {r_shift[6:0], w_mosi_sync};
                end else if (w_sck_fall) begin
                    r_miso  <= r_shift[7];
                end
            end
        end
    end

`ifdef K12A_SPI_SLAVE_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) r_overrun <= 1'b0;
        else          r_overrun <= (w_complete & r_rx_ready) |
                                   (r_overrun & ~bus.spi_slave_status_io_load);
    end

    assign w_overrun = r_overrun;
`else
    assign w_overrun = 1'b0;
`endif

    always_comb begin
        w_bus_en  = 1'b0;
        w_bus_val = 8'h00;
        if (bus.spi_slave_data_io_load) begin
            w_bus_en  = 1'b1;
            w_bus_val = r_rx_data;
        end else if (bus.spi_slave_status_io_load) begin
            w_bus_en  = 1'b1;
            w_bus_val = {5'b00000, w_selected, w_overrun, r_rx_ready};
        end
    end

    assign data_bus               = w_bus_en ? w_bus_val : 8'bzzzzzzzz;
    assign spi_miso               = w_selected ? r_miso : 1'bz;
    assign bus.spi_slave_rx_ready = r_rx_ready;
    assign bus.spi_slave_selected = w_selected;
endmodule

// File: tb/tb_k12a_spi_slave.sv
// Directed bench for k12a_spi_slave: a bit-banged SPI master and CPU bus strobes with hand-computed expectations.
module tb_k12a_spi_slave;
    logic       cpu_clock = 1'b0;
    logic       reset_n;
    wire  [7:0] data_bus;
    wire        spi_miso;
    logic [7:0] tb_bus_val;
    logic       tb_bus_en;
    int         n_tests = 0;
    int         n_fail  = 0;

`ifdef K12A_SPI_SLAVE_OVERRUN_EN
    localparam logic [7:0] ST_OVR = 8'h07;
`else
    localparam logic [7:0] ST_OVR = 8'h05;
`endif

    k12a_spi_slave_if bus_if();

    assign data_bus = tb_bus_en ? tb_bus_val : 8'bzzzzzzzz;

    k12a_spi_slave dut (
        .cpu_clock (cpu_clock),
        .reset_n   (reset_n),
        .bus       (bus_if),
        .data_bus  (data_bus),
        .spi_miso  (spi_miso)
    );

    always #5 cpu_clock = ~cpu_clock;

    task automatic tick(input int n);
        repeat (n) @(negedge cpu_clock);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_store(input logic [7:0] v);
        tb_bus_val = v;
        tb_bus_en  = 1'b1;
        bus_if.spi_slave_data_io_store = 1'b1;
        tick(1);
        bus_if.spi_slave_data_io_store = 1'b0;
        tb_bus_en  = 1'b0;
    endtask

    task automatic cpu_read_data(output logic [7:0] v);
        bus_if.spi_slave_data_io_load = 1'b1;
        #1 v = data_bus;
        tick(1);
        bus_if.spi_slave_data_io_load = 1'b0;
    endtask

    task automatic cpu_read_status(output logic [7:0] v);
        bus_if.spi_slave_status_io_load = 1'b1;
        #1 v = data_bus;
        tick(1);
        bus_if.spi_slave_status_io_load = 1'b0;
    endtask

    // one mode-0 bit: MOSI set in the low phase, MISO sampled just before SCK rises
    task automatic spi_bit(input logic b, output logic m);
        bus_if.spi_mosi = b;
        tick(4);
        m = spi_miso;
        bus_if.spi_sck = 1'b1;
        tick(4);
        bus_if.spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mo[i], b);
            mi[i] = b;
        end
    endtask

    task automatic select(input logic v);
        bus_if.spi_ss_n = v;
        tick(4);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] mi;
        logic       b;

        reset_n    = 1'b0;
        tb_bus_en  = 1'b0;
        tb_bus_val = 8'h00;
        bus_if.spi_slave_data_io_load   = 1'b0;
        bus_if.spi_slave_data_io_store  = 1'b0;
        bus_if.spi_slave_status_io_load = 1'b0;
        bus_if.spi_sck  = 1'b0;
        bus_if.spi_mosi = 1'b0;
        bus_if.spi_ss_n = 1'b1;
        tick(2);

        chk("rst_rx_ready", {7'b0, bus_if.spi_slave_rx_ready}, 8'h00);
        chk("rst_selected", {7'b0, bus_if.spi_slave_selected}, 8'h00);
        n_tests++;
        assert (spi_miso === 1'bz) else begin
            n_fail++;
            $error("FAIL rst_miso_z: observed %b required z", spi_miso);
        end
        n_tests++;
        assert (data_bus === 8'bzzzzzzzz) else begin
            n_fail++;
            $error("FAIL rst_bus_z: observed %h required zz", data_bus);
        end
        reset_n = 1'b1;
        tick(2);
        cpu_read_status(rd);
        chk("rst_status", rd, 8'h00);
        cpu_read_data(rd);
        chk("rst_rx_data", rd, 8'h00);

        // basic frame: send A5, receive 3C
        cpu_store(8'hA5);
        select(1'b0);
        chk("sel_after_ss", {7'b0, bus_if.spi_slave_selected}, 8'h01);
        spi_byte(8'h3C, mi);
        chk("miso_a5", mi, 8'hA5);
        chk("rdy_after_3c", {7'b0, bus_if.spi_slave_rx_ready}, 8'h01);
        cpu_read_data(rd);
        chk("rx_3c", rd, 8'h3C);
        chk("rdy_cleared", {7'b0, bus_if.spi_slave_rx_ready}, 8'h00);
        select(1'b1);
        chk("desel", {7'b0, bus_if.spi_slave_selected}, 8'h00);

        // back-to-back bytes without a read
        select(1'b0);
        spi_byte(8'h01, mi);
        spi_byte(8'h80, mi);
        chk("miso_b2b", mi, 8'hA5);
        cpu_read_status(rd);
        chk("status_b2b", rd, ST_OVR);
        cpu_read_data(rd);
        chk("rx_80", rd, 8'h80);
        select(1'b1);

        // aborted byte after five rising edges
        select(1'b0);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        select(1'b1);
        chk("abort_rdy", {7'b0, bus_if.spi_slave_rx_ready}, 8'h00);
        chk("abort_sel", {7'b0, bus_if.spi_slave_selected}, 8'h00);
        n_tests++;
        assert (spi_miso === 1'bz) else begin
            n_fail++;
            $error("FAIL abort_miso_z: observed %b required z", spi_miso);
        end
        // SCK toggling while idle must not count bits
        for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
        cpu_read_data(rd);
        chk("abort_rx_keep", rd, 8'h80);
        select(1'b0);
        spi_byte(8'hC3, mi);
        chk("after_abort_miso", mi, 8'hA5);
        cpu_read_data(rd);
        chk("after_abort_rx", rd, 8'hC3);
        select(1'b1);

        // data read in the same cycle as the 8th-edge capture
        select(1'b0);
        for (int i = 7; i >= 1; i--) spi_bit(((8'h96 >> i) & 8'h01) != 8'h00, b);
        bus_if.spi_mosi = 1'b0;
        tick(4);
        bus_if.spi_sck = 1'b1;
        tick(2);
        bus_if.spi_slave_data_io_load = 1'b1;
        #1 rd = data_bus;
        tick(1);
        bus_if.spi_slave_data_io_load = 1'b0;
        chk("coinc_old_rx", rd, 8'hC3);
        chk("coinc_rdy", {7'b0, bus_if.spi_slave_rx_ready}, 8'h01);
        tick(1);
        bus_if.spi_sck = 1'b0;
        tick(4);
        cpu_read_data(rd);
        chk("coinc_new_rx", rd, 8'h96);
        select(1'b1);

        // reset mid-byte
        select(1'b0);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        reset_n = 1'b0;
        #1;
        chk("midrst_sel", {7'b0, bus_if.spi_slave_selected}, 8'h00);
        chk("midrst_rdy", {7'b0, bus_if.spi_slave_rx_ready}, 8'h00);
        n_tests++;
        assert (spi_miso === 1'bz) else begin
            n_fail++;
            $error("FAIL midrst_miso_z: observed %b required z", spi_miso);
        end
        tick(2);
        reset_n = 1'b1;
        tick(4);
        chk("midrst_wait_edge", {7'b0, bus_if.spi_slave_selected}, 8'h00);
        select(1'b1);
        select(1'b0);
        spi_byte(8'hFF, mi);
        chk("midrst_miso", mi, 8'h00);
        cpu_read_data(rd);
        chk("midrst_rx_ff", rd, 8'hFF);
        select(1'b1);

        // store mid-byte takes effect at the next byte
        select(1'b0);
        for (int i = 7; i >= 5; i--) begin
            spi_bit(((8'hC5 >> i) & 8'h01) != 8'h00, b);
            mi[i] = b;
        end
        cpu_store(8'h5A);
        for (int i = 4; i >= 0; i--) begin
            spi_bit(((8'hC5 >> i) & 8'h01) != 8'h00, b);
            mi[i] = b;
        end
        chk("midstore_cur", mi, 8'h00);
        spi_byte(8'h69, mi);
        chk("midstore_next", mi, 8'h5A);
        cpu_read_status(rd);
        chk("midstore_status", rd, ST_OVR);
        cpu_read_data(rd);
        chk("midstore_rx", rd, 8'h69);
        select(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/k12a_spi_slave.md
K12A_SPI_SLAVE -- requirements
Module: k12a_spi_slave

Interface
REQ-001 SHALL have port cpu_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port spi_slave_data_io_load, input, 1 bit: CPU read of the receive register.
REQ-004 SHALL have port spi_slave_data_io_store, input, 1 bit: CPU write of the transmit register.
REQ-005 SHALL have port spi_slave_status_io_load, input, 1 bit: CPU read of the status byte.
REQ-006 SHALL have port spi_slave_rx_ready, output, 1 bit: an unread received byte is held.
REQ-007 SHALL have port spi_slave_selected, output, 1 bit: the state machine is in SHIFT.
REQ-008 SHALL have port data_bus, inout, 8 bits: shared CPU data bus; driven only during a load strobe, high-impedance otherwise.
REQ-009 SHALL have port spi_sck, input, 1 bit: serial clock from the external master.
REQ-010 SHALL have port spi_mosi, input, 1 bit: serial data from the master.
REQ-011 SHALL have port spi_ss_n, input, 1 bit: slave select, active-low.
REQ-012 SHALL have port spi_miso, output, 1 bit: serial data to the master; high-impedance while not selected.

Function
REQ-013 SHALL pass spi_sck, spi_mosi and spi_ss_n each through a 2-flop synchroniser, then a third flop for edge detection.
REQ-014 SHALL support SPI mode 0, MSB first, 8-bit frames, with each SCK high and low phase at least 3 cpu_clock periods.
REQ-015 SHALL have two states, IDLE and SHIFT: IDLE->SHIFT on synchronised ss_n falling; SHIFT->IDLE on synchronised ss_n high; no other transitions.
REQ-016 On entry to SHIFT, SHALL set the shift register to tx_data, the 3-bit bit counter to 0 and the MISO register to tx_data[7].
REQ-017 On each synchronised SCK rising edge in SHIFT, SHALL shift the register left with mosi_sync entering bit 0, and increment the counter (wraps 7->0).
REQ-018 On each synchronised SCK falling edge in SHIFT, SHALL load the MISO register with shift register bit 7.
REQ-019 On the rising edge with counter==7, SHALL in the same cycle load rx_data with {shift[6:0], mosi_sync}, set rx_ready and reload the shift register from tx_data, so back-to-back bytes need no gap.
REQ-020 SHALL assert rx_ready no later than 3 cpu_clock rising edges after the 8th SCK rising edge at the pin.
REQ-021 spi_slave_data_io_load SHALL drive rx_data onto data_bus combinationally and clear rx_ready at the end of that cycle.
REQ-022 If byte completion and spi_slave_data_io_load coincide, SHALL keep rx_ready=1; the bus shows the old rx_data and the new byte is captured.
REQ-023 spi_slave_data_io_store SHALL capture data_bus into tx_data; a store mid-byte SHALL NOT disturb the byte in flight and takes effect at the next byte boundary or SHIFT entry.
REQ-024 spi_slave_status_io_load SHALL drive {5'b0, selected, overrun, rx_ready} onto data_bus.
REQ-025 If ss_n deasserts mid-byte, SHALL discard the partial byte, leave rx_data and rx_ready unchanged and float spi_miso.
REQ-026 SCK edges while in IDLE SHALL be ignored.

Reset
REQ-027 While reset_n=0, SHALL hold: state=IDLE, shift=0x00, counter=0, rx_data=0x00, tx_data=0x00, rx_ready=0, overrun=0, MISO register=0, spi_slave_selected=0, spi_miso high-impedance, data_bus not driven.
REQ-028 Reset during SHIFT SHALL abort the byte; after release, the block SHALL wait for a fresh ss_n falling edge before shifting.

Configuration
REQ-029 With macro K12A_SPI_SLAVE_OVERRUN_EN defined, SHALL set the overrun flag when a byte completes while rx_ready=1, clear it at the end of a status read, and on coincidence keep it set.
REQ-030 Without K12A_SPI_SLAVE_OVERRUN_EN, status bit 1 SHALL read 0 and no overrun storage SHALL exist; rx_data is still overwritten on completion.

Verification
REQ-031 Store 0xA5; assert ss_n; master clocks in 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_ready=1; data read returns 0x3C; rx_ready then 0.
REQ-032 Two back-to-back bytes 0x01, 0x80 without a read -> rx_data=0x80; status=0x07 with the macro, 0x05 without.
REQ-033 ss_n deasserted after 5 SCK rising edges -> rx_ready stays 0, spi_miso=Z, spi_slave_selected=0; the next full frame receives correctly.
REQ-034 Data read issued in the same cycle as the 8th-edge capture -> bus shows the old value and rx_ready remains 1.
REQ-035 reset_n pulsed low mid-byte -> all outputs at reset values immediately; a subsequent frame 0xFF is received as 0xFF.
REQ-036 Store 0x5A after bit 3 of a byte whose tx_data=0x00 -> current byte sends 0x00; the next byte sends 0x5A.
